// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch, decode, execute,
// memory and write-back, and drives the datapath selects and write enables.
module riscv_multicycle_ctrl #(
  parameter int RESET_STALL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       IRWrite,
  output logic       Muxrs1,
  output logic       Muxrs2,
  output logic       RegWrite,
  output logic [1:0] WBSel,
  output logic       PCWrite,
  output logic [1:0] PCSel,
  output logic       illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [3:0] STALL_LAST = 4'(RESET_STALL - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] stall_cnt;

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_imm, is_reg;
  logic legal;

  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_imm    = (opcode == OP_IMM);
  assign is_reg    = (opcode == OP_REG);

  assign legal = is_lui | is_auipc | is_jal | (is_jalr & (funct3 == 3'b000)) |
                 is_branch | is_load | is_store | is_imm | is_reg;

  // The stall counter only advances in IDLE, which is reachable only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) stall_cnt <= stall_cnt + 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (stall_cnt == STALL_LAST) state_nxt = S_FETCH;
      S_FETCH:  if (imem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!legal)                  state_nxt = S_TRAP;
        else if (is_auipc || is_jal) state_nxt = S_WB;
        else                         state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (is_branch)                state_nxt = S_FETCH;
        else if (is_load || is_store) state_nxt = S_MEM;
        else                          state_nxt = S_WB;
      end
      S_MEM:    if (dmem_ready) state_nxt = is_load ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    IRWrite  = 1'b0;
    Muxrs1   = 1'b1;
    Muxrs2   = 1'b1;
    RegWrite = 1'b0;
    WBSel    = 2'd0;
    PCWrite  = 1'b0;
    PCSel    = 2'd0;
    illegal  = 1'b0;
    case (state)
      S_IDLE: begin
        Muxrs1 = 1'b0;
        Muxrs2 = 1'b0;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        IRWrite  = imem_ready;
      end
      S_EXEC: begin
        Muxrs1 = ~is_lui;
        Muxrs2 = ~(is_reg | is_branch);
        if (is_branch) begin
          PCWrite = 1'b1;
          PCSel   = branch_taken ? 2'd1 : 2'd0;
        end
      end
      S_MEM: begin
        // Operand selects stay as in EXEC so the address holds during wait states.
        Muxrs1   = ~is_lui;
        Muxrs2   = ~(is_reg | is_branch);
        dmem_req = 1'b1;
        dmem_we  = is_store;
        PCWrite  = is_store & dmem_ready;
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        if (is_load)                WBSel = 2'd1;
        else if (is_jal || is_jalr) WBSel = 2'd2;
        else if (is_auipc)          WBSel = 2'd3;
        if (is_jal)       PCSel = 2'd2;
        else if (is_jalr) PCSel = 2'd3;
      end
      S_TRAP: begin
        Muxrs1  = 1'b0;
        Muxrs2  = 1'b0;
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: an instruction-level model expands
// each instruction into per-cycle expected outputs; a monitor compares every cycle.
module tb_riscv_multicycle_ctrl;

  localparam int RESET_STALL = 1;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] LD    = 7'b0000011;
  localparam logic [6:0] ST    = 7'b0100011;
  localparam logic [6:0] OPI   = 7'b0010011;
  localparam logic [6:0] OPR   = 7'b0110011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       branch_taken = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, dmem_req, dmem_we, IRWrite, Muxrs1, Muxrs2, RegWrite;
  logic [1:0] WBSel, PCSel;
  logic       PCWrite, illegal;

  logic [12:0] exp_q[$];
  logic [12:0] act;
  logic [12:0] exp_v;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  riscv_multicycle_ctrl #(.RESET_STALL(RESET_STALL)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .IRWrite(IRWrite),
    .Muxrs1(Muxrs1), .Muxrs2(Muxrs2), .RegWrite(RegWrite), .WBSel(WBSel),
    .PCWrite(PCWrite), .PCSel(PCSel), .illegal(illegal)
  );

  assign act = {imem_req, dmem_req, dmem_we, IRWrite, Muxrs1, Muxrs2, RegWrite,
                WBSel, PCWrite, PCSel, illegal};

  function automatic logic [12:0] mk(input bit ireq, input bit dreq, input bit we,
                                     input bit irw, input bit m1, input bit m2,
                                     input bit rw, input logic [1:0] wbs, input bit pcw,
                                     input logic [1:0] pcs, input bit ill);
    return {ireq, dreq, we, irw, m1, m2, rw, wbs, pcw, pcs, ill};
  endfunction

  function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3);
    if (op == JALR) return f3 == 3'b000;
    return op inside {LUI, AUIPC, JAL, BR, LD, ST, OPI, OPR};
  endfunction

  // Monitor: one expected output vector per clock cycle.
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %b required %b (ireq dreq we irw m1 m2 rw wbsel pcw pcsel ill)",
                 cyc, act, exp_v);
      end
    end
  end

  task automatic step(input logic [12:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_inputs();
    opcode       = 7'($urandom);
    funct3       = 3'($urandom);
    branch_taken = 1'($urandom);
    imem_ready   = 1'($urandom);
    dmem_ready   = 1'($urandom);
  endtask

  task automatic hold_instr(input logic [6:0] op, input logic [2:0] f3);
    rnd_inputs();
    opcode = op;
    funct3 = f3;
  endtask

  task automatic do_reset(input int n_low);
    rst_n = 1'b0;
    repeat (n_low) begin
      rnd_inputs();
      step('0);
    end
    rst_n = 1'b1;
    repeat (RESET_STALL) begin
      rnd_inputs();
      step('0);
    end
  endtask

  // Fetch through end of instruction. When abort_mem >= 0 a STORE/LOAD is
  // interrupted by reset after that many MEM wait cycles.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input bit bt,
                       input int iw, input int dw, input int abort_mem = -1);
    bit m1, m2, st, ld;
    logic [1:0] wbs, pcs;
    repeat (iw) begin
      rnd_inputs();
      imem_ready = 1'b0;
      step(mk(1, 0, 0, 0, 1, 1, 0, 2'd0, 0, 2'd0, 0));
    end
    rnd_inputs();
    imem_ready = 1'b1;
    step(mk(1, 0, 0, 1, 1, 1, 0, 2'd0, 0, 2'd0, 0));
    hold_instr(op, f3);
    step(mk(0, 0, 0, 0, 1, 1, 0, 2'd0, 0, 2'd0, 0));
    if (!is_legal(op, f3)) begin
      repeat (12) begin
        hold_instr(op, f3);
        step(mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1));
      end
      return;
    end
    st = (op == ST);
    ld = (op == LD);
    if (op != AUIPC && op != JAL) begin
      m1 = (op != LUI);
      m2 = !(op == OPR || op == BR);
      hold_instr(op, f3);
      branch_taken = bt;
      if (op == BR) begin
        step(mk(0, 0, 0, 0, m1, m2, 0, 2'd0, 1, bt ? 2'd1 : 2'd0, 0));
        return;
      end
      step(mk(0, 0, 0, 0, m1, m2, 0, 2'd0, 0, 2'd0, 0));
      if (st || ld) begin
        for (int i = 0; i < dw; i++) begin
          hold_instr(op, f3);
          dmem_ready = 1'b0;
          if (i == abort_mem) begin
            rst_n = 1'b0;
            #1;
            checks++;
            if (dmem_req !== 1'b0 || PCWrite !== 1'b0 || RegWrite !== 1'b0) begin
              errors++;
              $display("FAIL async_reset_abort: dmem_req=%b PCWrite=%b RegWrite=%b required 0 0 0",
                       dmem_req, PCWrite, RegWrite);
            end
            step('0);
            do_reset(2);
            return;
          end
          step(mk(0, 1, st, 0, m1, m2, 0, 2'd0, 0, 2'd0, 0));
        end
        hold_instr(op, f3);
        dmem_ready = 1'b1;
        step(mk(0, 1, st, 0, m1, m2, 0, 2'd0, st, 2'd0, 0));
        if (st) return;
      end
    end
    wbs = ld ? 2'd1 : (op == JAL || op == JALR) ? 2'd2 : (op == AUIPC) ? 2'd3 : 2'd0;
    pcs = (op == JAL) ? 2'd2 : (op == JALR) ? 2'd3 : 2'd0;
    hold_instr(op, f3);
    step(mk(0, 0, 0, 0, 1, 1, 1, wbs, 1, pcs, 0));
  endtask

  initial begin
    logic [6:0] ops[9];
    logic [6:0] op;
    logic [2:0] f3;
    ops = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR};
    @(posedge clk);
    #1;
    do_reset(3);

    issue(OPI, 3'd0, 0, 0, 0);
    issue(LUI, 3'd5, 0, 0, 0);
    issue(OPR, 3'd2, 0, 0, 0);
    issue(LD, 3'd2, 0, 0, 3);
    issue(BR, 3'd0, 1, 0, 0);
    issue(BR, 3'd1, 0, 0, 0);
    issue(JALR, 3'd0, 0, 0, 0);
    issue(ST, 3'd2, 0, 0, 0);
    issue(AUIPC, 3'd7, 0, 2, 0);
    issue(JAL, 3'd3, 0, 1, 0);
    issue(ST, 3'd1, 0, 3, 2);

    for (int n = 0; n < 150; n++) begin
      op = ops[$urandom_range(0, 8)];
      f3 = (op == JALR) ? 3'd0 : 3'($urandom);
      issue(op, f3, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    issue(JALR, 3'b001, 0, 0, 0);
    do_reset(2);
    issue(7'b1111111, 3'd0, 0, 1, 0);
    do_reset(1);
    op = 7'b1111111;
    for (int k = 0; k < 100 && is_legal(op, 3'd0); k++) op = 7'($urandom);
    issue(op, 3'd0, 0, 0, 0);
    do_reset(1);

    issue(ST, 3'd2, 0, 0, 5, 2);
    issue(OPI, 3'd1, 0, 0, 0);
    issue(LD, 3'd0, 0, 1, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
